// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Build option: BCD2BIN_SATURATE_EN (see bcd_to_bin_seq.sv).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MAX_DIGIT  = 4'd9;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd_to_bin_seq_adj.sv
// Per-digit correction step of reverse double-dabble:
// a nibble of 8 or more after the right shift gets 3 subtracted.
module bcd_nibble_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? din - ADJ_VAL : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble step per clock.
// Define BCD2BIN_SATURATE_EN to clamp bin_out to all-ones on overflow.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int BCD_CNT   = 2,
  parameter int BIN_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [BCD_CNT*DIGIT_W-1:0] bcd_in,
  output logic [BIN_WIDTH-1:0]       bin_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       ovf
);

  localparam int BW = BCD_CNT * DIGIT_W;
  localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  state_t                 state;
  logic [BW-1:0]          bcd_reg;
  logic [BIN_WIDTH-1:0]   bin_reg;
  logic [CW-1:0]          cnt;

  logic [BW+BIN_WIDTH-1:0] shifted;
  logic [BW-1:0]           sh_bcd;
  logic [BW-1:0]           nxt_bcd;
  logic [BIN_WIDTH-1:0]    nxt_bin;
  logic [BCD_CNT-1:0]      dig_bad;
  logic                    bad;
  logic                    last;
  logic                    nxt_ovf;

  assign shifted = {bcd_reg, bin_reg} >> 1;
  assign sh_bcd  = shifted[BW+BIN_WIDTH-1 -: BW];
  assign nxt_bin = shifted[BIN_WIDTH-1:0];

  for (genvar i = 0; i < BCD_CNT; i++) begin : g_dig
    bcd_nibble_adj u_adj (
      .din  (sh_bcd[i*DIGIT_W +: DIGIT_W]),
      .dout (nxt_bcd[i*DIGIT_W +: DIGIT_W])
    );
    assign dig_bad[i] = bcd_in[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT;
  end

  assign bad     = |dig_bad;
  assign last    = (cnt == CW'(BIN_WIDTH - 1));
  // Any BCD residue left after the last step is value >> BIN_WIDTH.
  assign nxt_ovf = |nxt_bcd;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (bad) begin
              state   <= DONE;
              bin_out <= '0;
              err     <= 1'b1;
              ovf     <= 1'b0;
            end else begin
              state   <= SHIFT;
              bcd_reg <= bcd_in;
              bin_reg <= '0;
              cnt     <= '0;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= nxt_bcd;
          bin_reg <= nxt_bin;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            err   <= 1'b0;
            ovf   <= nxt_ovf;
`ifdef BCD2BIN_SATURATE_EN
            bin_out <= nxt_ovf ? {BIN_WIDTH{1'b1}} : nxt_bin;
`else
            bin_out <= nxt_bin;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: default 2-digit instance plus a
// 3-digit instance for the overflow cases.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        start;
  logic [7:0]  bcd_in;
  logic [7:0]  bin_out;
  logic        busy, done, err, ovf;

  logic        start3;
  logic [11:0] bcd_in3;
  logic [7:0]  bin_out3;
  logic        busy3, done3, err3, ovf3;

  int n_vec = 0;
  int n_err = 0;

`ifdef BCD2BIN_SATURATE_EN
  localparam logic [7:0] EXP_300 = 8'd255;
`else
  localparam logic [7:0] EXP_300 = 8'd44;
`endif

  always #5 clk = ~clk;

  bcd_to_bin_seq dut (
    .clk(clk), .rstn(rstn), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  bcd_to_bin_seq #(.BCD_CNT(3), .BIN_WIDTH(8)) dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .bcd_in(bcd_in3),
    .bin_out(bin_out3), .busy(busy3), .done(done3), .err(err3), .ovf(ovf3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start = 0; bcd_in = 0; start3 = 0; bcd_in3 = 0;
    rstn = 0;
    #12;
    n_vec++;
    if ({busy, done, err, ovf, bin_out} !== 12'h000) begin
      n_err++;
      $display("FAIL reset: busy/done/err/ovf/bin=%b%b%b%b/%0d want 0000/0",
               busy, done, err, ovf, bin_out);
    end
    n_vec++;
    if ({busy3, done3, err3, ovf3, bin_out3} !== 12'h000) begin
      n_err++;
      $display("FAIL reset3: busy/done/err/ovf/bin=%b%b%b%b/%0d want 0000/0",
               busy3, done3, err3, ovf3, bin_out3);
    end
    @(negedge clk);
    rstn = 1;
    step();
  endtask

  task automatic test_convert_99();
    bcd_in = 8'h99; start = 1;
    step();
    start = 0;
    for (int c = 1; c <= 9; c++) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL c99_busy cyc%0d: got %b want 1", c, busy);
      end
      n_vec++;
      if (done !== (c == 9)) begin
        n_err++;
        $display("FAIL c99_done cyc%0d: got %b want %b", c, done, c == 9);
      end
      if (c != 9) step();
    end
    n_vec++;
    if ({err, ovf, bin_out} !== {2'b00, 8'd99}) begin
      n_err++;
      $display("FAIL c99_result: err/ovf/bin=%b%b/%0d want 00/99", err, ovf, bin_out);
    end
    step();
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL c99_idle: busy/done=%b%b want 00", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    bcd_in = 8'h00; start = 1;
    step();
    bcd_in = 8'h42;
    for (int c = 1; c < 9; c++) step();
    n_vec++;
    if ({done, bin_out} !== {1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL b2b_first: done/bin=%b/%0d want 1/0", done, bin_out);
    end
    step();
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_gap: busy/done=%b%b want 00", busy, done);
    end
    step();
    start = 0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    for (int c = 11; c < 19; c++) step();
    n_vec++;
    if ({done, bin_out} !== {1'b1, 8'd42}) begin
      n_err++;
      $display("FAIL b2b_second: done/bin=%b/%0d want 1/42", done, bin_out);
    end
    step();
  endtask

  task automatic test_err();
    bcd_in = 8'hA5; start = 1;
    step();
    start = 0;
    n_vec++;
    if ({done, err, ovf, bin_out} !== {3'b110, 8'd0}) begin
      n_err++;
      $display("FAIL err_a5: done/err/ovf/bin=%b%b%b/%0d want 110/0",
               done, err, ovf, bin_out);
    end
    step();
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL err_idle: busy/done=%b%b want 00", busy, done);
    end
    bcd_in = 8'h17; start = 1;
    step();
    start = 0;
    for (int c = 1; c < 9; c++) step();
    n_vec++;
    if ({done, err, ovf, bin_out} !== {3'b100, 8'd17}) begin
      n_err++;
      $display("FAIL err_then_17: done/err/ovf/bin=%b%b%b/%0d want 100/17",
               done, err, ovf, bin_out);
    end
    step();
  endtask

  task automatic test_wide();
    logic [11:0] vin [2]  = '{12'h255, 12'h300};
    logic [7:0]  vbin [2] = '{8'd255, EXP_300};
    logic        vovf [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      bcd_in3 = vin[k]; start3 = 1;
      step();
      start3 = 0;
      for (int c = 1; c < 9; c++) step();
      n_vec++;
      if ({done3, err3, ovf3, bin_out3} !== {2'b10, vovf[k], vbin[k]}) begin
        n_err++;
        $display("FAIL wide_%h: done/err/ovf/bin=%b%b%b/%0d want 10%b/%0d",
                 vin[k], done3, err3, ovf3, bin_out3, vovf[k], vbin[k]);
      end
      step();
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    bcd_in = 8'h36; start = 1;
    step();
    start = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) pulses++;
      if (c == 3 || c == 9) begin
        start = 1; bcd_in = 8'h99;
      end else begin
        start = 0;
      end
      if (c == 9) begin
        n_vec++;
        if ({done, bin_out} !== {1'b1, 8'd36}) begin
          n_err++;
          $display("FAIL ign_result: done/bin=%b/%0d want 1/36", done, bin_out);
        end
      end
      step();
    end
    start = 0;
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL ign_pulses: got %0d want 1", pulses);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ign_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    bcd_in3 = 12'h300; start3 = 1;
    bcd_in = 8'h63; start = 1;
    step();
    start = 0; start3 = 0;
    for (int c = 1; c < 4; c++) step();
    rstn = 0;
    #1;
    n_vec++;
    if ({busy, done, err, ovf, bin_out} !== 12'h000) begin
      n_err++;
      $display("FAIL abort_clear: busy/done/err/ovf/bin=%b%b%b%b/%0d want 0000/0",
               busy, done, err, ovf, bin_out);
    end
    n_vec++;
    if ({busy3, ovf3, bin_out3} !== 10'h000) begin
      n_err++;
      $display("FAIL abort_clear3: busy/ovf/bin=%b%b/%0d want 00/0",
               busy3, ovf3, bin_out3);
    end
    @(negedge clk);
    rstn = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL abort_nodone: got %0d pulses want 0", pulses);
    end
    bcd_in = 8'h63; start = 1;
    step();
    start = 0;
    for (int c = 1; c < 9; c++) step();
    n_vec++;
    if ({done, err, ovf, bin_out} !== {3'b100, 8'd63}) begin
      n_err++;
      $display("FAIL abort_fresh: done/err/ovf/bin=%b%b%b/%0d want 100/63",
               done, err, ovf, bin_out);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_convert_99();
    test_back_to_back();
    test_err();
    test_wide();
    test_ignore_start();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
